// File: rtl/fft_out_reorder_if.sv
// Port bundle of fft_out_reorder: bin-tagged input stream (no backpressure) and the
// natural-order output stream. Output transfers on a cycle where oen && ordy are both high;
// once oen is raised the word stays stable until it has been transferred.
interface fft_out_reorder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              ien;
   logic [ADDR_W-1:0] iaddr;
   logic [DATA_W-1:0] idata;
   logic              oen;
   logic              ordy;
   logic [ADDR_W-1:0] oaddr;
   logic [DATA_W-1:0] odata;
   logic              osof;
   logic              oeof;
   logic              ovf;

   modport slave (
      input  ien, iaddr, idata, ordy,
      output oen, oaddr, odata, osof, oeof, ovf
   );

   modport master (
      output ien, iaddr, idata, ordy,
      input  oen, oaddr, odata, osof, oeof, ovf
   );
endinterface

// File: rtl/fft_out_reorder.sv
// Collects one frame of bin-tagged FFT samples into a ping-pong RAM bank and replays it
// in natural bin order through a registered valid/ready output with a one-entry skid.
module fft_out_reorder #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic             iclk,
   input  logic             rst_n,
   fft_out_reorder_if.slave bus,
   output logic [1:0]       dbg_state
);
   localparam int N = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N - 1);
   localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(N - 1);

   typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_READING} bank_st_e;
   typedef enum logic {W_WRITE, W_WAIT} wr_st_e;
   typedef enum logic {R_IDLE, R_READ} rd_st_e;

   bank_st_e          bank_st [2];
   wr_st_e            wr_st;
   logic              wr_bank;
   logic [ADDR_W:0]   wr_cnt;
   rd_st_e            rd_st;
   logic              rd_bank;
   logic [ADDR_W-1:0] rd_cnt;

   logic [DATA_W-1:0] mem [2*N];
   logic [DATA_W-1:0] ram_q;
   logic              p_v, p_bank;
   logic [ADDR_W-1:0] p_addr;
   logic              s_v, s_bank;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_data;
   logic              o_bank;

   logic              full0, full1, any_full, pick;
   logic              free_now, other_bank, other_free;
   logic [1:0]        occ;
   logic              can_issue, do_issue, iss_bank, wr_accept;
   logic [ADDR_W-1:0] iss_addr;

   assign dbg_state = {wr_st, rd_st};

   always_comb begin
      full0      = (bank_st[0] == B_FULL);
      full1      = (bank_st[1] == B_FULL);
      any_full   = full0 | full1;
      // With both banks full the writer is parked on the newer one.
      pick       = (full0 && full1) ? ~wr_bank : full1;
      free_now   = bus.oen && bus.ordy && bus.oeof;
      other_bank = ~wr_bank;
      other_free = (bank_st[other_bank] == B_FREE) || (free_now && (o_bank == other_bank));
      wr_accept  = bus.ien && (wr_st == W_WRITE);
      // A read may issue only if output+skid will have room when its data lands.
      occ        = {1'b0, bus.oen} + {1'b0, s_v} + {1'b0, p_v} - {1'b0, bus.oen && bus.ordy};
      can_issue  = (occ <= 2'd1);
      if (rd_st == R_IDLE) begin
         iss_bank = pick;
         iss_addr = '0;
         do_issue = can_issue && any_full;
      end else begin
         iss_bank = rd_bank;
         iss_addr = rd_cnt;
         do_issue = can_issue;
      end
   end

   always_ff @(posedge iclk) begin
      if (wr_accept) mem[{wr_bank, bus.iaddr}] <= bus.idata;
      if (do_issue) ram_q <= mem[{iss_bank, iss_addr}];
   end

   always_ff @(posedge iclk) begin
      if (!rst_n) begin
         bank_st[0] <= B_FREE;
         bank_st[1] <= B_FREE;
         wr_st      <= W_WRITE;
         wr_bank    <= 1'b0;
         wr_cnt     <= '0;
         rd_st      <= R_IDLE;
         rd_bank    <= 1'b0;
         rd_cnt     <= '0;
         p_v        <= 1'b0;
         p_bank     <= 1'b0;
         p_addr     <= '0;
         s_v        <= 1'b0;
         s_bank     <= 1'b0;
         s_addr     <= '0;
         s_data     <= '0;
         o_bank     <= 1'b0;
         bus.oen    <= 1'b0;
         bus.oaddr  <= '0;
         bus.odata  <= '0;
         bus.osof   <= 1'b0;
         bus.oeof   <= 1'b0;
         bus.ovf    <= 1'b0;
      end else begin
         if (wr_st == W_WRITE) begin
            if (bus.ien) begin
               if (wr_cnt == LAST_CNT) begin
                  bank_st[wr_bank] <= B_FULL;
                  wr_cnt           <= '0;
                  if (other_free) wr_bank <= other_bank;
                  else            wr_st   <= W_WAIT;
               end else begin
                  bank_st[wr_bank] <= B_FILLING;
                  wr_cnt           <= wr_cnt + 1'b1;
               end
            end
         end else begin
            if (bus.ien) bus.ovf <= 1'b1;
            if (other_free) begin
               wr_st   <= W_WRITE;
               wr_bank <= other_bank;
            end
         end

         // Bin 0 of the next full bank issues straight from IDLE, so frames chain without a bubble.
         if (do_issue) begin
            if (rd_st == R_IDLE) begin
               bank_st[pick] <= B_READING;
               rd_bank       <= pick;
            end
            if (iss_addr == LAST_BIN) begin
               rd_st  <= R_IDLE;
               rd_cnt <= '0;
            end else begin
               rd_st  <= R_READ;
               rd_cnt <= iss_addr + 1'b1;
            end
         end
         p_v    <= do_issue;
         p_bank <= iss_bank;
         p_addr <= iss_addr;

         if (!bus.oen || bus.ordy) begin
            if (s_v) begin
               bus.oen   <= 1'b1;
               bus.oaddr <= s_addr;
               bus.odata <= s_data;
               bus.osof  <= (s_addr == '0);
               bus.oeof  <= (s_addr == LAST_BIN);
               o_bank    <= s_bank;
               s_v       <= p_v;
               s_addr    <= p_addr;
               s_data    <= ram_q;
               s_bank    <= p_bank;
            end else if (p_v) begin
               bus.oen   <= 1'b1;
               bus.oaddr <= p_addr;
               bus.odata <= ram_q;
               bus.osof  <= (p_addr == '0);
               bus.oeof  <= (p_addr == LAST_BIN);
               o_bank    <= p_bank;
            end else begin
               bus.oen   <= 1'b0;
            end
         end else if (p_v) begin
            s_v    <= 1'b1;
            s_addr <= p_addr;
            s_data <= ram_q;
            s_bank <= p_bank;
         end

         if (free_now) bank_st[o_bank] <= B_FREE;
      end
   end
endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: frame-level reference model (buffered-frame count, expected
// output queue) checks every output transfer, holds during stalls, and the drop flag.
module tb_fft_out_reorder;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 32;
   localparam int N      = 8;
   localparam int W      = ADDR_W + DATA_W;

   logic       iclk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   fft_out_reorder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   fft_out_reorder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .iclk      (iclk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   always #5 iclk = ~iclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: completed frames waiting or being read, and the words they must produce.
   logic [W-1:0]      exp_q[$];
   logic [DATA_W-1:0] m_frame [N];
   int                m_wcnt = 0;
   int                m_outstanding = 0;
   bit                m_blocked = 1'b0;
   bit                m_ovf = 1'b0;
   int                m_xfers = 0;
   bit                prev_stall = 1'b0;
   logic [W+1:0]      prev_out;
   logic [W-1:0]      mon_e;

   always @(negedge iclk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_wcnt        = 0;
         m_outstanding = 0;
         m_blocked     = 1'b0;
         m_ovf         = 1'b0;
         prev_stall    = 1'b0;
      end else begin
         check_eq("ovf", 64'(bus.ovf), 64'(m_ovf));
         if (prev_stall) begin
            check_eq("hold_oen", 64'(bus.oen), 64'(1));
            check_eq("hold_word", 64'({bus.oaddr, bus.odata, bus.osof, bus.oeof}), 64'(prev_out));
         end
         if (bus.oen && bus.ordy) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_oen", 64'(bus.oen), 64'(0));
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("out_word", 64'({bus.oaddr, bus.odata}), 64'(mon_e));
               check_eq("out_sof", 64'(bus.osof), 64'(mon_e[W-1:DATA_W] == 0));
               check_eq("out_eof", 64'(bus.oeof), 64'(mon_e[W-1:DATA_W] == ADDR_W'(N - 1)));
               m_xfers++;
               if (mon_e[W-1:DATA_W] == ADDR_W'(N - 1)) m_outstanding--;
            end
         end
         prev_stall = bus.oen && !bus.ordy;
         prev_out   = {bus.oaddr, bus.odata, bus.osof, bus.oeof};
         if (bus.ien) begin
            if (m_blocked) begin
               m_ovf = 1'b1;
            end else begin
               m_frame[bus.iaddr] = bus.idata;
               m_wcnt++;
               if (m_wcnt == N) begin
                  for (int i = 0; i < N; i++) exp_q.push_back({ADDR_W'(i), m_frame[i]});
                  m_outstanding++;
                  m_wcnt = 0;
               end
            end
         end
         m_blocked = (m_outstanding == 2);
      end
   end

   // ordy pattern generator: 0 always ready, 1 pattern 1,0,0,1, 2 held low, 3 random.
   int ordy_mode = 0;
   int ordy_ph   = 0;
   initial begin
      bus.ordy = 1'b1;
      forever begin
         @(posedge iclk);
         #1;
         case (ordy_mode)
            0: bus.ordy = 1'b1;
            1: begin
               bus.ordy = ((ordy_ph % 4) == 0) || ((ordy_ph % 4) == 3);
               ordy_ph++;
            end
            2: bus.ordy = 1'b0;
            default: bus.ordy = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge iclk);
         #1;
      end
   endtask

   // kind 0: bit-reversed order, data = base+bin; kind 1: random order and data.
   task automatic send_frame(input int kind, input logic [DATA_W-1:0] base, input int count);
      int order [N];
      int j, t, r;
      for (int i = 0; i < N; i++) begin
         r = 0;
         for (int b = 0; b < ADDR_W; b++) if (((i >> b) & 1) != 0) r |= 1 << (ADDR_W - 1 - b);
         order[i] = (kind == 0) ? r : i;
      end
      if (kind != 0) begin
         for (int i = N - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
         end
      end
      for (int k = 0; k < count; k++) begin
         bus.ien   = 1'b1;
         bus.iaddr = ADDR_W'(order[k]);
         bus.idata = (kind == 0) ? base + DATA_W'(order[k]) : $urandom;
         @(posedge iclk);
         #1;
      end
      bus.ien = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || bus.oen) && k < budget) begin
         @(posedge iclk);
         #1;
         k++;
      end
      check_eq(tag, 64'(k >= budget), 64'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_oen"},   64'(bus.oen),   64'(0));
      check_eq({tag, "_oaddr"}, 64'(bus.oaddr), 64'(0));
      check_eq({tag, "_odata"}, 64'(bus.odata), 64'(0));
      check_eq({tag, "_osof"},  64'(bus.osof),  64'(0));
      check_eq({tag, "_oeof"},  64'(bus.oeof),  64'(0));
      check_eq({tag, "_ovf"},   64'(bus.ovf),   64'(0));
   endtask

   initial begin
      int x0, w, cnt;
      bus.ien   = 1'b0;
      bus.iaddr = '0;
      bus.idata = '0;
      rst_n     = 1'b0;
      repeat (3) @(posedge iclk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      idle(2);

      // T1: bit-reversed frame, latency and first word
      ordy_mode = 0;
      x0 = m_xfers;
      send_frame(0, 32'h1000, N);
      @(negedge iclk); check_eq("t1_lat0", 64'(bus.oen), 64'(0));
      @(negedge iclk); check_eq("t1_lat1", 64'(bus.oen), 64'(0));
      @(negedge iclk); check_eq("t1_lat2", 64'(bus.oen), 64'(1));
      check_eq("t1_first_addr", 64'(bus.oaddr), 64'(0));
      check_eq("t1_first_data", 64'(bus.odata), 64'(32'h1000));
      check_eq("t1_first_sof",  64'(bus.osof),  64'(1));
      wait_drain("t1_drain", 100);
      check_eq("t1_count", 64'(m_xfers - x0), 64'(8));

      // T2: pairs of back-to-back frames stream out as 16 contiguous words
      for (int p = 0; p < 2; p++) begin
         fork
            begin
               send_frame(1, '0, N);
               send_frame(1, '0, N);
            end
            begin
               w = 0;
               while (!bus.oen && w < 30) begin
                  @(negedge iclk);
                  w++;
               end
               check_eq("t2_oen_seen", 64'(bus.oen), 64'(1));
               cnt = 0;
               while (bus.oen && cnt < 40) begin
                  cnt++;
                  @(negedge iclk);
               end
               check_eq("t2_contig", 64'(cnt), 64'(16));
            end
         join
         wait_drain("t2_drain", 100);
         check_eq("t2_ovf", 64'(bus.ovf), 64'(0));
      end

      // T3: ordy 1,0,0,1 pattern
      ordy_mode = 1;
      x0 = m_xfers;
      send_frame(0, 32'h1000, N);
      wait_drain("t3_drain", 200);
      check_eq("t3_count", 64'(m_xfers - x0), 64'(8));

      // T4: output blocked for three frames, third one dropped
      ordy_mode = 2;
      idle(2);
      x0 = m_xfers;
      for (int f = 0; f < 3; f++) send_frame(1, '0, N);
      idle(1);
      check_eq("t4_ovf_set", 64'(bus.ovf), 64'(1));
      ordy_mode = 0;
      wait_drain("t4_drain", 200);
      check_eq("t4_count", 64'(m_xfers - x0), 64'(16));
      send_frame(1, '0, N);
      wait_drain("t4_drain2", 200);
      check_eq("t4_count2", 64'(m_xfers - x0), 64'(24));
      check_eq("t4_ovf_sticky", 64'(bus.ovf), 64'(1));

      // T5: reset with a buffered frame and a partial frame in flight
      ordy_mode = 2;
      idle(1);
      send_frame(1, '0, N);
      send_frame(1, '0, 5);
      rst_n = 1'b0;
      @(posedge iclk);
      #1;
      check_reset_outputs("t5_rst");
      @(posedge iclk);
      #1;
      rst_n = 1'b1;
      ordy_mode = 0;
      x0 = m_xfers;
      idle(4);
      check_eq("t5_quiet", 64'(bus.oen), 64'(0));
      send_frame(1, '0, N);
      wait_drain("t5_drain", 100);
      check_eq("t5_count", 64'(m_xfers - x0), 64'(8));
      check_eq("t5_ovf", 64'(bus.ovf), 64'(0));

      // T6: frame B completes on the edge frame A's last bin transfers; C follows at once
      ordy_mode = 0;
      idle(2);
      x0 = m_xfers;
      send_frame(1, '0, N);
      idle(2);
      send_frame(1, '0, N);
      send_frame(1, '0, N);
      wait_drain("t6_drain", 200);
      check_eq("t6_count", 64'(m_xfers - x0), 64'(24));
      check_eq("t6_ovf", 64'(bus.ovf), 64'(0));

      // T7: random frames, random gaps, random ordy
      ordy_mode = 3;
      x0 = m_xfers;
      for (int f = 0; f < 10; f++) begin
         w = 0;
         while (m_blocked && w < 300) begin
            @(posedge iclk);
            #1;
            w++;
         end
         check_eq("t7_unblock", 64'(w >= 300), 64'(0));
         idle(int'($urandom_range(0, 3)));
         send_frame(1, '0, N);
      end
      wait_drain("t7_drain", 1000);
      check_eq("t7_count", 64'(m_xfers - x0), 64'(80));
      check_eq("t7_ovf", 64'(bus.ovf), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
